// File: rtl/cy_status_reg_wide.sv
// cy_status_reg_wide: up to 32 status bits. Each bit is either transparent or
// sticky, and sticky bits can capture a level or a rising edge. A read handshake
// takes an atomic snapshot and clears the sticky bits. A masked OR of the status
// bits drives a level or pulse interrupt.
// Optional build macro: CY_STATUS_REG_WIDE_SYNC_EN adds a 2-flop input synchroniser.
module cy_status_reg_wide #(
  parameter int unsigned Width      = 8,
  parameter logic [31:0] StickyMask = 32'h0,
  parameter logic [31:0] EdgeMask   = 32'h0,
  parameter logic [31:0] IntMask    = 32'h0,
  parameter bit          IntPulse   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] status,
  input  logic             rd_req,
  input  logic             rd_ack,
  output logic [Width-1:0] rd_data,
  output logic             rd_valid,
  input  logic             mask_wr,
  input  logic [Width-1:0] mask_in,
  output logic             intr
);

  localparam logic [Width-1:0] StickyM = StickyMask[Width-1:0];
  localparam logic [Width-1:0] EdgeM   = EdgeMask[Width-1:0];
  localparam logic [Width-1:0] IntM    = IntMask[Width-1:0];

  typedef enum logic [1:0] {StIdle, StSnap, StHold} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] stat_in;
  logic [Width-1:0] prev_q;
  logic [Width-1:0] sts_q, sts_d;
  logic [Width-1:0] set_term, clr_term;
  logic [Width-1:0] rd_data_q, rd_data_d;
  logic [Width-1:0] mask_q, mask_d;
  logic             any_d, any_q;
  logic             intr_q, intr_d;

`ifdef CY_STATUS_REG_WIDE_SYNC_EN
  logic [Width-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for asynchronous status nets.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= status;
      sync2_q <= sync1_q;
    end
  end

  assign stat_in = sync2_q;
`else
  assign stat_in = status;
`endif

  // Set/clear terms and next status value. Set wins over a same-cycle clear,
  // so an event landing in the SNAP cycle survives into the next read.
  always_comb begin
    set_term = stat_in & (~prev_q | ~EdgeM);
    clr_term = '0;
    if (state_q == StSnap) begin
      clr_term = sts_q & StickyM;
    end
    sts_d = (StickyM & ((sts_q & ~clr_term) | set_term)) | (~StickyM & stat_in);
  end

  // Read handshake FSM and snapshot register.
  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          state_d = StSnap;
        end
      end
      StSnap: begin
        rd_data_d = sts_q;
        state_d   = StHold;
      end
      StHold: begin
        if (rd_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Interrupt mask and interrupt output generation.
  always_comb begin
    mask_d = mask_wr ? mask_in : mask_q;
    any_d  = |(sts_q & mask_q);
    if (IntPulse) begin
      intr_d = any_d & ~any_q;
    end else begin
      intr_d = any_d;
    end
  end

  // All state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      prev_q    <= '0;
      sts_q     <= '0;
      rd_data_q <= '0;
      mask_q    <= IntM;
      any_q     <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= stat_in;
      sts_q     <= sts_d;
      rd_data_q <= rd_data_d;
      mask_q    <= mask_d;
      any_q     <= any_d;
      intr_q    <= intr_d;
    end
  end

  // rd_valid decodes straight from state so reset drops it asynchronously.
  assign rd_valid = (state_q == StHold);
  assign rd_data  = rd_data_q;
  assign intr     = intr_q;

endmodule
